s_axil_cfg_regs: RTL and testbench

AXI4-Lite slave register file that holds the counter-writer configuration. It sits directly upstream of the AXI counter write master and drives that block's configuration array: enable, 64-bit target address, length and increment step. It also returns the master's FSM state through a read-only STATUS register, so software configures and monitors the counter over a single AXI4-Lite port.

---
 rtl/axi_cfg_pkg.sv | 27 ++
 rtl/s_axil_cfg_regs_if.sv | 39 +++
 rtl/s_axil_cfg_regs.sv | 195 +++++++++++++++++++
 tb/tb_s_axil_cfg_regs.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_cfg_pkg.sv
// Shared definitions for the counter-writer configuration register file:
// register indices, AXI response codes and the read/write FSM states.
package axi_cfg_pkg;

    typedef enum logic [2:0] {
        ENABLED   = 3'd0,
        ADDR_W_0  = 3'd1,
        ADDR_W_1  = 3'd2,
        LENGTH    = 3'd3,
        INCR_STEP = 3'd4,
        STATUS    = 3'd5
    } REG_TYPE;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/s_axil_cfg_regs_if.sv
// AXI4-Lite bus bundle for the configuration register file. Signal suffixes
// (_i/_o) are named from the slave's point of view.
interface s_axil_cfg_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr_i;
    logic                    awvalid_i;
    logic                    awready_o;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic [DATA_WIDTH/8-1:0] wstrb_i;
    logic                    wvalid_i;
    logic                    wready_o;
    logic [1:0]              bresp_o;
    logic                    bvalid_o;
    logic                    bready_i;
    logic [ADDR_WIDTH-1:0]   araddr_i;
    logic                    arvalid_i;
    logic                    arready_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic [1:0]              rresp_o;
    logic                    rvalid_o;
    logic                    rready_i;

    modport slave (
        input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
               araddr_i, arvalid_i, rready_i,
        output awready_o, wready_o, bresp_o, bvalid_o,
               arready_o, rdata_o, rresp_o, rvalid_o
    );

    modport master (
        output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
               araddr_i, arvalid_i, rready_i,
        input  awready_o, wready_o, bresp_o, bvalid_o,
               arready_o, rdata_o, rresp_o, rvalid_o
    );

endinterface

// File: rtl/s_axil_cfg_regs.sv
// AXI4-Lite configuration registers for the counter write master.
// Optional macro CFG_REGS_LOCK_EN: while ENABLED[0] is set, indices 1-4 are write-protected.
module s_axil_cfg_regs
    import axi_cfg_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int REG_QUANTITY = 6
) (
    input  logic                                   clk,
    input  logic                                   areset,
    s_axil_cfg_regs_if.slave                       s_axil,
    output logic [REG_QUANTITY-1:0][DATA_WIDTH-1:0] regs_o,
    input  logic [2:0]                             status_i
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef logic [REG_QUANTITY-1:0][DATA_WIDTH-1:0] reg_array_t;

    wr_state_e             wr_state_q, wr_state_d;
    logic                  aw_held_q, aw_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic [1:0]            bresp_q, bresp_d;
    reg_array_t            regs_q, regs_d;

    rd_state_e             rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic [DATA_WIDTH-1:0] status_word;
    logic [IDX_W-1:0]      ar_idx;
    logic                  bvalid;
    logic                  wr_hit;
    logic                  wr_locked;
    logic                  unused_addr_lsbs;

    function automatic logic [DATA_WIDTH-1:0] apply_strb(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]     strb
    );
        apply_strb = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) apply_strb[8*b +: 8] = new_v[8*b +: 8];
        end
    endfunction

    assign status_word      = {{(DATA_WIDTH-3){1'b0}}, status_i};
    assign ar_idx           = s_axil.araddr_i[ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^{s_axil.awaddr_i[1:0], s_axil.araddr_i[1:0]};
    assign bvalid           = (wr_state_q == WR_RESP);

    assign s_axil.awready_o = ~aw_held_q & ~bvalid;
    assign s_axil.wready_o  = ~w_held_q & ~bvalid;
    assign s_axil.bvalid_o  = bvalid;
    assign s_axil.bresp_o   = bresp_q;
    assign s_axil.arready_o = (rd_state_q == RD_IDLE);
    assign s_axil.rvalid_o  = (rd_state_q == RD_DATA);
    assign s_axil.rdata_o   = rdata_q;
    assign s_axil.rresp_o   = rresp_q;

    // STATUS is never stored; the live master state is substituted in its slot.
    always_comb begin
        regs_o         = regs_q;
        regs_o[STATUS] = status_word;
    end

`ifdef CFG_REGS_LOCK_EN
    assign wr_locked = regs_q[ENABLED][0]
                     && (aw_idx_q >= IDX_W'(ADDR_W_0))
                     && (aw_idx_q <= IDX_W'(INCR_STEP));
`else
    assign wr_locked = 1'b0;
`endif

    always_comb begin
        wr_hit = 1'b0;
        for (int i = 0; i < REG_QUANTITY; i++) begin
            if (i != int'(STATUS) && aw_idx_q == IDX_W'(i)) wr_hit = 1'b1;
        end
    end

    // NOTE: every combinational output gets a default before any branch, so no
    // path through the block can leave a value unassigned and infer a latch.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;

        if (s_axil.awvalid_i && s_axil.awready_o) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axil.awaddr_i[ADDR_WIDTH-1:2];
        end
        if (s_axil.wvalid_i && s_axil.wready_o) begin
            w_held_d = 1'b1;
            w_data_d = s_axil.wdata_i;
            w_strb_d = s_axil.wstrb_i;
        end

        unique case (wr_state_q)
            WR_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = WR_RESP;
                    if (wr_hit && !wr_locked) begin
                        bresp_d = RESP_OKAY;
                        for (int i = 0; i < REG_QUANTITY; i++) begin
                            if (i != int'(STATUS) && aw_idx_q == IDX_W'(i)) begin
                                regs_d[i] = apply_strb(regs_q[i], w_data_q, w_strb_q);
                            end
                        end
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end
            end
            WR_RESP: begin
                if (s_axil.bready_i) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase

        // ENABLED holds a single flag; its upper bits always read back as zero.
        regs_d[ENABLED][DATA_WIDTH-1:1] = '0;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        unique case (rd_state_q)
            RD_IDLE: begin
                if (s_axil.arvalid_i) begin
                    rd_state_d = RD_DATA;
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    for (int i = 0; i < REG_QUANTITY; i++) begin
                        if (ar_idx == IDX_W'(i)) begin
                            rresp_d = RESP_OKAY;
                            rdata_d = (i == int'(STATUS)) ? status_word : regs_q[i];
                        end
                    end
                end
            end
            RD_DATA: begin
                if (s_axil.rready_i) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of its peers. The register array is reset too:
    // the counter master must see a defined, disabled configuration after reset.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= RESP_OKAY;
            regs_q     <= '0;
            rd_state_q <= RD_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_s_axil_cfg_regs.sv
// Self-checking bench for s_axil_cfg_regs: directed protocol/timing steps plus
// randomized register traffic checked against an array-based register model.
`timescale 1ns/1ps
module tb_s_axil_cfg_regs;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int NREG = 6;

    logic                      clk = 1'b0;
    logic                      areset = 1'b0;
    logic [NREG-1:0][DW-1:0]   regs_o;
    logic [2:0]                status_i = 3'd0;

    s_axil_cfg_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    s_axil_cfg_regs #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .REG_QUANTITY(NREG)
    ) dut (
        .clk     (clk),
        .areset  (areset),
        .s_axil  (bus),
        .regs_o  (regs_o),
        .status_i(status_i)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model [NREG];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [NREG*DW-1:0] obs, input logic [NREG*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG*DW-1:0] exp_regs();
        logic [NREG*DW-1:0] v;
        for (int i = 0; i < NREG; i++) v[i*DW +: DW] = model[i];
        v[5*DW +: DW] = {29'b0, status_i};
        return v;
    endfunction

    // Applies a write to the model and returns the response the slave owes.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx = int'(addr >> 2);
        if (idx >= NREG || idx == 5) return 2'b10;
`ifdef CFG_REGS_LOCK_EN
        if (idx >= 1 && idx <= 4 && model[0][0]) return 2'b10;
`endif
        for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        if (idx == 0) model[0] = model[0] & 32'h1;
        return 2'b00;
    endfunction

    task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
        int idx = int'(addr >> 2);
        if (idx >= NREG) begin d = '0; r = 2'b10; end
        else if (idx == 5) begin d = {29'b0, status_i}; r = 2'b00; end
        else begin d = model[idx]; r = 2'b00; end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit ad = 0, wd = 0;
        int n = 0;
        @(negedge clk);
        bus.awaddr_i = addr; bus.awvalid_i = 1'b1;
        bus.wdata_i = data; bus.wstrb_i = strb; bus.wvalid_i = 1'b1;
        bus.bready_i = 1'b1;
        while (!(ad && wd) && n < 20) begin
            if (bus.awvalid_i && bus.awready_o) ad = 1;
            if (bus.wvalid_i && bus.wready_o) wd = 1;
            @(negedge clk);
            if (ad) bus.awvalid_i = 1'b0;
            if (wd) bus.wvalid_i = 1'b0;
            n++;
        end
        check("wr_accept_timeout", (n >= 20), 0);
        n = 0;
        while (!bus.bvalid_o && n < 20) begin @(negedge clk); n++; end
        check("bvalid_timeout", (n >= 20), 0);
        resp = bus.bresp_o;
        @(negedge clk);
        bus.bready_i = 1'b0;
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        bus.araddr_i = addr; bus.arvalid_i = 1'b1;
        while (!bus.arready_o && n < 20) begin @(negedge clk); n++; end
        check("arready_timeout", (n >= 20), 0);
        @(negedge clk);
        bus.arvalid_i = 1'b0;
        check("rvalid_latency", bus.rvalid_o, 1);
        data = bus.rdata_o;
        resp = bus.rresp_o;
        bus.rready_i = 1'b1;
        @(negedge clk);
        bus.rready_i = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp, exp_resp;
        logic [31:0] rdat, exp_d, addr, data;
        logic [3:0]  strb;

        bus.awaddr_i = '0; bus.awvalid_i = 1'b0; bus.wdata_i = '0; bus.wstrb_i = '0;
        bus.wvalid_i = 1'b0; bus.bready_i = 1'b0; bus.araddr_i = '0; bus.arvalid_i = 1'b0;
        bus.rready_i = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;

        // Reset state
        status_i = 3'd6;
        repeat (3) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        check("rst_regs", regs_o, exp_regs());
        check("rst_bvalid", bus.bvalid_o, 0);
        check("rst_rvalid", bus.rvalid_o, 0);
        check("rst_bresp", bus.bresp_o, 0);
        check("rst_rresp", bus.rresp_o, 0);
        check("rst_rdata", bus.rdata_o, 0);
        check("rst_readies", {bus.awready_o, bus.wready_o, bus.arready_o}, 3'b111);

        // ENABLED write with AW and W together: commit one edge after the handshake
        bus.awaddr_i = 32'h0; bus.wdata_i = 32'hFFFF_FFFF; bus.wstrb_i = 4'hF;
        bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1;
        @(negedge clk);
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        check("en_before_commit", regs_o, exp_regs());
        check("bvalid_before_commit", bus.bvalid_o, 0);
        exp_resp = model_write(32'h0, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        check("en_after_commit", regs_o, exp_regs());
        check("en_reg0_is_1", regs_o[0], 32'h1);
        check("en_bvalid", bus.bvalid_o, 1);
        check("en_bresp", bus.bresp_o, exp_resp);
        bus.bready_i = 1'b1;
        @(negedge clk);
        bus.bready_i = 1'b0;
        check("en_bvalid_cleared", bus.bvalid_o, 0);
        axi_write(32'h0, 32'h0, 4'hF, resp);
        check("en_clear_resp", resp, model_write(32'h0, 32'h0, 4'hF));

        // LENGTH with partial strobes, then read back
        axi_write(32'hC, 32'h1122_3344, 4'hF, resp);
        check("len_full_resp", resp, model_write(32'hC, 32'h1122_3344, 4'hF));
        axi_write(32'hC, 32'hAABB_CCDD, 4'h3, resp);
        check("len_strb_resp", resp, model_write(32'hC, 32'hAABB_CCDD, 4'h3));
        check("len_strb_reg", regs_o[3], 32'h1122_CCDD);
        axi_read(32'hC, rdat, resp);
        check("len_read_data", rdat, 32'h1122_CCDD);
        check("len_read_resp", resp, 2'b00);

        // Read sampled on the commit edge returns the pre-commit value; rdata holds until rready
        @(negedge clk);
        bus.awaddr_i = 32'hC; bus.wdata_i = 32'h5555_6666; bus.wstrb_i = 4'hF;
        bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1;
        @(negedge clk);
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        bus.araddr_i = 32'hC; bus.arvalid_i = 1'b1;
        exp_d = model[3];
        exp_resp = model_write(32'hC, 32'h5555_6666, 4'hF);
        @(negedge clk);
        bus.arvalid_i = 1'b0;
        check("rd_on_commit_data", bus.rdata_o, exp_d);
        check("rd_on_commit_regs", regs_o, exp_regs());
        check("rd_on_commit_bresp", bus.bresp_o, exp_resp);
        repeat (2) begin
            @(negedge clk);
            check("rd_stall_rvalid", bus.rvalid_o, 1);
            check("rd_stall_rdata", bus.rdata_o, exp_d);
            check("rd_stall_arready", bus.arready_o, 0);
        end
        bus.rready_i = 1'b1; bus.bready_i = 1'b1;
        @(negedge clk);
        bus.rready_i = 1'b0; bus.bready_i = 1'b0;
        check("rd_stall_done", {bus.rvalid_o, bus.bvalid_o}, 2'b00);

        // W presented three cycles before AW: one commit, one edge after AW handshake
        bus.wdata_i = 32'hCAFE_0001; bus.wstrb_i = 4'hF; bus.wvalid_i = 1'b1;
        @(negedge clk);
        bus.wvalid_i = 1'b0;
        check("w_first_wready_low", bus.wready_o, 0);
        repeat (2) @(negedge clk);
        check("w_first_no_bvalid", bus.bvalid_o, 0);
        bus.awaddr_i = 32'h10; bus.awvalid_i = 1'b1;
        @(negedge clk);
        bus.awvalid_i = 1'b0;
        check("w_first_bvalid_early", bus.bvalid_o, 0);
        check("w_first_regs_early", regs_o, exp_regs());
        exp_resp = model_write(32'h10, 32'hCAFE_0001, 4'hF);
        @(negedge clk);
        check("w_first_bvalid", bus.bvalid_o, 1);
        check("w_first_bresp", bus.bresp_o, exp_resp);
        check("w_first_regs", regs_o, exp_regs());
        bus.bready_i = 1'b1;
        @(negedge clk);
        bus.bready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("w_first_single_commit", {bus.bvalid_o, bus.awready_o, bus.wready_o}, 3'b011);
        end

        // Out-of-range and STATUS accesses
        axi_read(32'h1C, rdat, resp);
        check("oor_read_data", rdat, 0);
        check("oor_read_resp", resp, 2'b10);
        axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, resp);
        check("status_write_resp", resp, 2'b10);
        check("status_write_regs", regs_o, exp_regs());
        status_i = 3'd2;
        axi_read(32'h14, rdat, resp);
        check("status_read_data", rdat, 32'h2);
        check("status_read_resp", resp, 2'b00);

        // Write response held off by bready low for five cycles
        @(negedge clk);
        bus.awaddr_i = 32'h18; bus.wdata_i = 32'h1234_5678; bus.wstrb_i = 4'hF;
        bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1;
        @(negedge clk);
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        exp_resp = model_write(32'h18, 32'h1234_5678, 4'hF);
        repeat (5) begin
            @(negedge clk);
            check("bstall_bvalid", bus.bvalid_o, 1);
            check("bstall_bresp", bus.bresp_o, exp_resp);
            check("bstall_readies", {bus.awready_o, bus.wready_o}, 2'b00);
        end
        bus.bready_i = 1'b1;
        @(negedge clk);
        bus.bready_i = 1'b0;
        check("bstall_release", {bus.bvalid_o, bus.awready_o, bus.wready_o}, 3'b011);
        check("bstall_regs", regs_o, exp_regs());

        // Randomized traffic against the register model
        for (int it = 0; it < 60; it++) begin
            status_i = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 9) ? 32'h100 + 32'($urandom_range(0, 255))
                                               : 32'($urandom_range(0, 31));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(addr, data, strb, resp);
                check("rand_wr_resp", resp, model_write(addr, data, strb));
                check("rand_wr_regs", regs_o, exp_regs());
            end else begin
                axi_read(addr, rdat, resp);
                model_read(addr, exp_d, exp_resp);
                check("rand_rd_data", rdat, exp_d);
                check("rand_rd_resp", resp, exp_resp);
            end
        end

`ifdef CFG_REGS_LOCK_EN
        axi_write(32'h0, 32'h1, 4'hF, resp);
        check("lock_en_resp", resp, model_write(32'h0, 32'h1, 4'hF));
        axi_write(32'h10, 32'h5, 4'hF, resp);
        check("lock_incr_resp", resp, 2'b10);
        exp_resp = model_write(32'h10, 32'h5, 4'hF);
        check("lock_incr_regs", regs_o, exp_regs());
`endif

        // Asynchronous reset while a response is pending
        axi_write(32'h8, 32'hDEAD_BEEF, 4'hF, resp);
        check("pre_rst_resp", resp, model_write(32'h8, 32'hDEAD_BEEF, 4'hF));
        @(negedge clk);
        bus.awaddr_i = 32'h18; bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1;
        @(negedge clk);
        bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", bus.bvalid_o, 1);
        check("pre_rst_bresp", bus.bresp_o, 2'b10);
        #2 areset = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        #1;
        check("mid_rst_regs", regs_o, exp_regs());
        check("mid_rst_bvalid", bus.bvalid_o, 0);
        check("mid_rst_bresp", bus.bresp_o, 0);
        check("mid_rst_rd", {bus.rvalid_o, bus.rresp_o, bus.rdata_o}, 0);
        @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        check("post_rst_readies", {bus.awready_o, bus.wready_o, bus.arready_o, bus.bvalid_o}, 4'b1110);
        check("post_rst_regs", regs_o, exp_regs());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
